// File: rtl/switch_debounce_sampler_if.sv
// Valid/ack handshake carrying debounced switch values to the BCD converter.
interface switch_debounce_sampler_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0] bin_num;
  logic             bin_valid;
  logic             bin_ack;
  logic             overrun;

  modport master (output bin_num, output bin_valid, output overrun, input bin_ack);
  modport slave  (input bin_num, input bin_valid, input overrun, output bin_ack);
endinterface

// File: rtl/switch_debounce_sampler.sv
// Synchronises and debounces the switch bus, then offers stable changes over a
// one-deep buffered valid/ack handshake. Optional counter debounce: SW_DEBOUNCE_EN.
module switch_debounce_sampler #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [WIDTH-1:0]           sw,
  switch_debounce_sampler_if.master  bin_if
);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync_sw_r;
  logic [WIDTH-1:0] candidate_r;
  logic [WIDTH-1:0] last_val_r;
  logic [WIDTH-1:0] bin_num_r;
  logic [WIDTH-1:0] pending_val_r;
  logic             event_done_r;
  logic             bin_valid_r;
  logic             pending_flag_r;
  logic             overrun_r;
  state_t           state_r;
  logic             settled_s;
  logic             stable_s;
  logic             change_s;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES out of range 1..65535");
  end

`ifdef SW_DEBOUNCE_EN
  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);
  logic [15:0] stable_cnt_r;

  // Counts consecutive matching samples, saturating at CNT_MAX.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_cnt_r <= 16'd0;
    end else if (sync_sw_r != candidate_r) begin
      stable_cnt_r <= 16'd0;
    end else if (stable_cnt_r != CNT_MAX) begin
      stable_cnt_r <= stable_cnt_r + 16'd1;
    end else begin
      stable_cnt_r <= stable_cnt_r;
    end
  end

  assign settled_s = (stable_cnt_r == CNT_MAX);
`else
  assign settled_s = 1'b1;
`endif

  // Two-flop synchroniser for the asynchronous switch bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r   <= {WIDTH{1'b0}};
      sync_sw_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r   <= sw;
      sync_sw_r <= sync1_r;
    end
  end

  // event_done_r limits each candidate reload to a single stable event.
  assign stable_s = (sync_sw_r == candidate_r) && settled_s && !event_done_r;
  assign change_s = stable_s && (candidate_r != last_val_r);

  // Candidate tracking: reload on any difference, remember the event was taken.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      candidate_r  <= {WIDTH{1'b0}};
      event_done_r <= 1'b0;
    end else if (sync_sw_r != candidate_r) begin
      candidate_r  <= sync_sw_r;
      event_done_r <= 1'b0;
    end else if (stable_s) begin
      event_done_r <= 1'b1;
    end else begin
      event_done_r <= event_done_r;
    end
  end

  // Handshake FSM with one pending slot behind the presented value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      bin_num_r      <= {WIDTH{1'b0}};
      bin_valid_r    <= 1'b0;
      pending_val_r  <= {WIDTH{1'b0}};
      pending_flag_r <= 1'b0;
      last_val_r     <= {WIDTH{1'b0}};
      overrun_r      <= 1'b0;
    end else begin
      overrun_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (change_s) begin
            bin_num_r   <= candidate_r;
            bin_valid_r <= 1'b1;
            last_val_r  <= candidate_r;
            state_r     <= PRESENT;
          end
        end
        PRESENT: begin
          if (bin_if.bin_ack) begin
            if (pending_flag_r) begin
              bin_num_r <= pending_val_r;
              if (change_s) begin
                pending_val_r <= candidate_r;
                last_val_r    <= candidate_r;
              end else begin
                pending_flag_r <= 1'b0;
              end
            end else if (change_s) begin
              // Accepted and refilled in the same cycle: valid stays high.
              bin_num_r  <= candidate_r;
              last_val_r <= candidate_r;
            end else begin
              bin_valid_r <= 1'b0;
              state_r     <= IDLE;
            end
          end else if (change_s) begin
            pending_val_r  <= candidate_r;
            pending_flag_r <= 1'b1;
            overrun_r      <= pending_flag_r;
            last_val_r     <= candidate_r;
          end
        end
        default: begin
          state_r     <= IDLE;
          bin_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bin_if.bin_num   = bin_num_r;
  assign bin_if.bin_valid = bin_valid_r;
  assign bin_if.overrun   = overrun_r;

endmodule
